// File: rtl/axis_vlw_serializer_pkg.sv
// Shared defaults, derived sizes and FSM state type for the VLW-word to
// AXI-stream serializer.
package axis_vlw_serializer_pkg;

  localparam int VLW_WDT_DEF   = 64;
  localparam int TDATA_WDT_DEF = 32;
  localparam int ADDR_WDT_DEF  = 12;
  localparam int FIFO_SIZE_DEF = 16;

  localparam int RATIO_DEF   = VLW_WDT_DEF / TDATA_WDT_DEF;
  localparam int FIFO_AW_DEF = $clog2(FIFO_SIZE_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Index width that stays at least one bit even for a single-entry range.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/axis_vlw_serializer_if.sv
// AXI-stream beat bus between the serializer (master) and the DMA side (slave).
interface axis_vlw_serializer_if #(
  parameter int TDATA_WDT = axis_vlw_serializer_pkg::TDATA_WDT_DEF
) ();

  logic                 tvalid;
  logic                 tready;
  logic [TDATA_WDT-1:0] tdata;
  logic                 tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_vlw_serializer_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the oldest entry,
// count reports occupancy, rst flushes synchronously.
module axis_sync_fifo
  import axis_vlw_serializer_pkg::*;
#(
  parameter int WIDTH = VLW_WDT_DEF + 1,
  parameter int DEPTH = FIFO_SIZE_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                rd_data,
  output logic [clog2_min1(DEPTH):0]      count,
  output logic                            empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign do_push_s = push && (count_r != FULL_CNT);
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axis_vlw_serializer.sv
// Reads a power-of-two frame of VLW words from memory and streams them out as
// RATIO narrower AXI-stream beats per word, TLAST on the final beat.
module axis_vlw_serializer
  import axis_vlw_serializer_pkg::*;
#(
  parameter int VLW_WDT   = VLW_WDT_DEF,
  parameter int TDATA_WDT = TDATA_WDT_DEF,
  parameter int ADDR_WDT  = ADDR_WDT_DEF,
  parameter int FIFO_SIZE = FIFO_SIZE_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(ADDR_WDT+1)-1:0]  frame_len_log2,
  input  logic [ADDR_WDT-1:0]            base_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic [ADDR_WDT-1:0]            mem_rd_addr,
  input  logic [VLW_WDT-1:0]             mem_rd_data,
  axis_vlw_serializer_if.master          m_axis
);

  localparam int RATIO   = VLW_WDT / TDATA_WDT;
  localparam int BEAT_W  = clog2_min1(RATIO);
  localparam int FIFO_AW = clog2_min1(FIFO_SIZE);
  localparam int LEN_W   = ADDR_WDT + 1;
  localparam int FL_W    = $clog2(ADDR_WDT + 1);
  localparam int CRED_W  = FIFO_AW + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
  localparam logic [FL_W-1:0]   FL_MAX    = FL_W'(ADDR_WDT);

  state_t                state_r, state_s;
  logic                  load_s, issue_s, done_s;
  logic [LEN_W-1:0]      len_r, rd_cnt_r;
  logic [ADDR_WDT-1:0]   base_r, mem_rd_addr_r;
  logic                  mem_rd_en_r, rd_last_r, rd_valid_r, rd_valid_last_r, done_r;
  logic [FL_W-1:0]       fl_clamped_s;
  logic [LEN_W-1:0]      frame_words_s, issue_idx_s, issue_len_s;
  logic [ADDR_WDT-1:0]   issue_base_s;
  logic [CRED_W-1:0]     credit_use_s;
  logic                  credit_ok_s;
  logic [VLW_WDT:0]      fifo_rd_data_s;
  logic [FIFO_AW:0]      fifo_count_s;
  logic                  fifo_empty_s;
  logic [BEAT_W-1:0]     beat_r;
  logic                  last_beat_s, hs_s, pop_s, tlast_s;
  int                    shift_s;
  logic [TDATA_WDT-1:0]  beat_data_s;

  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign mem_rd_en   = mem_rd_en_r;
  assign mem_rd_addr = mem_rd_addr_r;

  // Words awaiting output plus reads whose data has not landed yet must fit;
  // a pop this cycle frees its slot for the read decided at this edge.
  assign credit_use_s = CRED_W'(fifo_count_s) + CRED_W'(rd_valid_r) + CRED_W'(mem_rd_en_r);
  assign credit_ok_s  = credit_use_s < (CRED_W'(FIFO_SIZE) + CRED_W'(pop_s));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: first read goes out with the accepted start (FIFO is empty in IDLE).
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    issue_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = READ;
          load_s  = 1'b1;
          issue_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (rd_cnt_r == len_r) begin
          state_s = DRAIN;
        end else begin
          issue_s = credit_ok_s;
        end
      end
      DRAIN: begin
        if (hs_s && tlast_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Clamp the requested length and select counters for the read issued this cycle.
  always_comb begin
    fl_clamped_s  = (frame_len_log2 > FL_MAX) ? FL_MAX : frame_len_log2;
    frame_words_s = LEN_W'(1) << fl_clamped_s;
    if (load_s) begin
      issue_idx_s  = '0;
      issue_len_s  = frame_words_s;
      issue_base_s = base_addr;
    end else begin
      issue_idx_s  = rd_cnt_r;
      issue_len_s  = len_r;
      issue_base_s = base_r;
    end
  end

  // Frame parameters captured with an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r  <= '0;
      base_r <= '0;
    end else if (load_s) begin
      len_r  <= frame_words_s;
      base_r <= base_addr;
    end else begin
      len_r  <= len_r;
      base_r <= base_r;
    end
  end

  // Read issue: address wraps modulo the memory size by plain truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r      <= '0;
      mem_rd_en_r   <= 1'b0;
      mem_rd_addr_r <= '0;
      rd_last_r     <= 1'b0;
    end else if (issue_s) begin
      rd_cnt_r      <= issue_idx_s + LEN_W'(1);
      mem_rd_en_r   <= 1'b1;
      mem_rd_addr_r <= issue_base_s + issue_idx_s[ADDR_WDT-1:0];
      rd_last_r     <= (issue_idx_s == issue_len_s - LEN_W'(1));
    end else begin
      mem_rd_en_r   <= 1'b0;
    end
  end

  // Return path: memory data is valid one cycle after the strobe; reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r      <= 1'b0;
      rd_valid_last_r <= 1'b0;
    end else begin
      rd_valid_r      <= mem_rd_en_r;
      rd_valid_last_r <= rd_last_r;
    end
  end

  axis_sync_fifo #(
    .WIDTH (VLW_WDT + 1),
    .DEPTH (FIFO_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_valid_r),
    .wr_data ({rd_valid_last_r, mem_rd_data}),
    .pop     (pop_s),
    .rd_data (fifo_rd_data_s),
    .count   (fifo_count_s),
    .empty   (fifo_empty_s)
  );

  // The FIFO head is the word being serialized; it only moves after its last beat.
  assign last_beat_s = (beat_r == LAST_BEAT);
  assign hs_s        = !fifo_empty_s && m_axis.tready;
  assign pop_s       = hs_s && last_beat_s;
  assign tlast_s     = !fifo_empty_s && fifo_rd_data_s[VLW_WDT] && last_beat_s;

  // Beat slice selection in the configured order.
  always_comb begin
    shift_s = 0;
    if (MSB_FIRST) begin
      shift_s = (RATIO - 1 - int'(beat_r)) * TDATA_WDT;
    end else begin
      shift_s = int'(beat_r) * TDATA_WDT;
    end
    beat_data_s = TDATA_WDT'(fifo_rd_data_s[VLW_WDT-1:0] >> shift_s);
  end

  assign m_axis.tvalid = !fifo_empty_s;
  assign m_axis.tdata  = fifo_empty_s ? '0 : beat_data_s;
  assign m_axis.tlast  = tlast_s;

  // Beat index within the current word advances on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= '0;
    end else if (hs_s) begin
      beat_r <= last_beat_s ? '0 : beat_r + BEAT_W'(1);
    end else begin
      beat_r <= beat_r;
    end
  end

  // Completion pulse one cycle after the final beat handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_s;
    end
  end

endmodule

// File: tb/tb_axis_vlw_serializer.sv
// Scoreboard bench: stimulus pushes expected reads/beats computed from the
// frame rules; negedge monitors compare whatever the DUTs present.
`timescale 1ns/1ps
module tb_axis_vlw_serializer;
  import axis_vlw_serializer_pkg::*;

  localparam int VW = 64, TW = 32, AW = 12, FS = 16, RAT = VW / TW, MEMW = 1 << AW;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, start2 = 1'b0;
  logic [3:0]    fl = 4'd0, fl2 = 4'd0;
  logic [AW-1:0] base = '0, base2 = '0;
  logic          busy, done, rd_en, busy2, done2, rd_en2;
  logic [AW-1:0] rd_addr, rd_addr2;
  logic [VW-1:0] rd_data, rd_data2;
  logic [VW-1:0] mem [MEMW];

  axis_vlw_serializer_if #(.TDATA_WDT(TW)) axm ();
  axis_vlw_serializer_if #(.TDATA_WDT(TW)) axl ();

  axis_vlw_serializer dut (
    .clk(clk), .rst(rst), .start(start), .frame_len_log2(fl), .base_addr(base),
    .busy(busy), .done(done), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr),
    .mem_rd_data(rd_data), .m_axis(axm)
  );

  axis_vlw_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start2), .frame_len_log2(fl2), .base_addr(base2),
    .busy(busy2), .done(done2), .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2),
    .mem_rd_data(rd_data2), .m_axis(axl)
  );

  // Memory model: one-cycle read latency for both read ports.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= mem[rd_addr];
    if (rd_en2) rd_data2 <= mem[rd_addr2];
  end

  int n_tests = 0, n_fail = 0;
  beat_t exp_q[$], exp_q2[$];
  logic [AW-1:0] addr_q[$];
  int unsigned issued = 0, hs_total = 0;
  bit exp_done = 1'b0, pend = 1'b0, rand_ready = 1'b0;
  beat_t pend_b, e, e2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] slice(input logic [VW-1:0] w, input int b, input bit msb);
    logic [VW-1:0] t;
    t = msb ? (w >> (VW - TW * (b + 1))) : (w >> (TW * b));
    return t[TW-1:0];
  endfunction

  // Queue the reads and beats a frame must produce, then pulse start.
  task automatic start_frame(input logic [3:0] f, input logic [AW-1:0] b);
    int n;
    logic [AW-1:0] a;
    beat_t x;
    n = 1 << ((int'(f) > AW) ? AW : int'(f));
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(b) + i) % MEMW);
      addr_q.push_back(a);
      for (int k = 0; k < RAT; k++) begin
        x.data = slice(mem[a], k, 1'b1);
        x.last = (i == n - 1) && (k == RAT - 1);
        exp_q.push_back(x);
      end
    end
    fl = f; base = b; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      cyc();
      c++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_beats_left"}, exp_q.size(), 0);
    check({name, "_reads_left"}, addr_q.size(), 0);
  endtask

  // Ready driver: always ready, or a fair coin per cycle.
  initial begin
    axl.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axm.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Main monitor: read addresses, credit bound, beats, hold stability, done pulse.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; exp_done = 1'b0; issued = 0; hs_total = 0;
      exp_q.delete(); addr_q.delete();
    end else begin
      if (pend) begin
        check("hold_valid", axm.tvalid, 1);
        check("hold_data", {axm.tdata, axm.tlast}, {pend_b.data, pend_b.last});
      end
      if (done || exp_done) begin
        check("done_pulse", done, exp_done);
        check("busy_with_done", busy, 0);
      end
      exp_done = 1'b0;
      if (rd_en) begin
        issued++;
        if (addr_q.size() == 0) check("rd_unexpected", addr_q.size(), 1);
        else check("rd_addr", rd_addr, addr_q.pop_front());
        check("credit", (issued - hs_total / RAT) <= FS, 1);
      end
      if (axm.tvalid && axm.tready) begin
        hs_total++;
        if (exp_q.size() == 0) check("beat_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("beat", {axm.tdata, axm.tlast}, {e.data, e.last});
          if (e.last) exp_done = 1'b1;
        end
      end
      pend = axm.tvalid && !axm.tready;
      pend_b.data = axm.tdata;
      pend_b.last = axm.tlast;
    end
  end

  // LSB-first instance monitor.
  always @(negedge clk) begin
    if (!rst && axl.tvalid && axl.tready) begin
      if (exp_q2.size() == 0) check("lsb_unexpected", exp_q2.size(), 1);
      else begin
        e2 = exp_q2.pop_front();
        check("lsb_beat", {axl.tdata, axl.tlast}, {e2.data, e2.last});
      end
    end
  end

  initial begin
    int c;
    int unsigned snap;
    beat_t x;
    for (int i = 0; i < MEMW; i++) mem[i] = {32'(i), ~32'(i)};
    repeat (3) cyc();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_tvalid", axm.tvalid, 0);
    check("rst_tdata", axm.tdata, 0);
    check("rst_tlast", axm.tlast, 0);
    check("rst_lsb", {busy2, axl.tvalid}, 0);
    rst = 1'b0;
    cyc();

    // Basic frame with start-to-first-beat latency checks.
    start_frame(4'd2, 12'd0);
    check("t1_busy_c1", busy, 1);
    check("t1_rden_c1", rd_en, 1);
    check("t1_tvalid_c1", axm.tvalid, 0);
    cyc();
    check("t1_tvalid_c2", axm.tvalid, 0);
    cyc();
    check("t1_tvalid_c3", axm.tvalid, 1);
    wait_done(200, "t1");

    // Address wrap past the top of memory.
    start_frame(4'd2, 12'd4094);
    wait_done(200, "t2");

    // Full-size frame, random data, random backpressure.
    for (int i = 0; i < MEMW; i++) mem[i] = {$urandom, $urandom};
    rand_ready = 1'b1;
    start_frame(4'd12, AW'($urandom));
    wait_done(40000, "t3");
    rand_ready = 1'b0;

    // Start while busy is ignored; reset mid-frame aborts cleanly.
    start_frame(4'd3, AW'($urandom));
    cyc();
    fl = 4'd1; base = base + 12'd100; start = 1'b1;
    cyc();
    start = 1'b0;
    snap = hs_total;
    c = 0;
    while (hs_total < snap + 5 && c < 200) begin
      cyc();
      c++;
    end
    check("t4_reach_beat5", hs_total >= snap + 5, 1);
    rst = 1'b1;
    cyc();
    check("t4_rst_outputs", {busy, done, rd_en, rd_addr, axm.tvalid, axm.tdata, axm.tlast}, 0);
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    check("t4_idle_after_rst", {busy, axm.tvalid, rd_en}, 0);
    start_frame(4'd2, AW'($urandom));
    wait_done(200, "t4b");

    // Oversized length clamps to the full memory.
    start_frame(4'd15, 12'd0);
    wait_done(20000, "t5");

    // LSB-first beat order.
    mem[0] = 64'h1111_1111_2222_2222;
    x.data = 32'h2222_2222; x.last = 1'b0; exp_q2.push_back(x);
    x.data = 32'h1111_1111; x.last = 1'b1; exp_q2.push_back(x);
    fl2 = 4'd0; base2 = 12'd0; start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    c = 0;
    while (done2 !== 1'b1 && c < 100) begin
      cyc();
      c++;
    end
    check("t6_done", done2, 1);
    check("t6_beats_left", exp_q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_vlw_serializer.md
# axis_vlw_serializer

Parametrised memory-to-AXI-stream master that reads a frame of VLW_WDT-bit FFT result words from the FFT result memory and emits them as TDATA_WDT-bit AXI-stream beats with TLAST on the final beat. It generalises the fixed 64/32-bit, fixed-size master path: width ratio, FIFO depth, beat order, base offset and frame length (runtime, power of two) are all configurable. It sits between the FFT output memory read port and the DMA-facing AXI-stream master port.

## Interface
- VLW_WDT, 64, memory word width (re in upper half, im in lower half)
- TDATA_WDT, 32, stream beat width; VLW_WDT % TDATA_WDT == 0; RATIO = VLW_WDT/TDATA_WDT ≥ 1
- ADDR_WDT, 12, memory address width; max frame = 2**ADDR_WDT words
- FIFO_SIZE, 16, word-FIFO depth (power of two, ≥ 4)
- MSB_FIRST, 1, 1: beat 0 = bits [VLW_WDT-1 -: TDATA_WDT]; 0: beat 0 = bits [0 +: TDATA_WDT]
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle frame request; sampled only in IDLE
- frame_len_log2  in  $clog2(ADDR_WDT+1)  log2 frame words, sampled with start; values > ADDR_WDT clamp to ADDR_WDT
- base_addr  in  ADDR_WDT  first word address, sampled with start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after final beat handshake
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ADDR_WDT  read address
- mem_rd_data  in  VLW_WDT  read data, valid exactly 1 cycle after mem_rd_en
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  TDATA_WDT  beat data
- m_axis_tlast  out  1  last beat of frame

## Operation
- FSM: IDLE → READ on start; READ → DRAIN when all N = 2**frame_len_log2 reads issued; DRAIN → IDLE on handshake of final beat (done pulses that cycle+1, busy falls same cycle as done).
- start while busy: ignored, no effect on frame in progress.
- Read i (0..N-1) uses address (base_addr + i) mod 2**ADDR_WDT; wrap past top of memory is legal.
- Credit rule: mem_rd_en asserted only if fifo_count + reads_in_flight < FIFO_SIZE; FIFO never overflows, no data dropped.
- Returned word written into FIFO with last-word flag (i == N-1).
- Output serializer pops one word, emits RATIO beats in MSB_FIRST order; pops next word on handshake of beat RATIO-1.
- tlast = last-word flag AND beat index == RATIO-1; total beats per frame = N*RATIO.
- AXI rules: once tvalid high, tdata/tlast held stable until tready; tvalid never depends combinationally on tready.
- RATIO == 1: pass-through, one beat per word.
- rst mid-frame: FSM → IDLE, FIFO flushed, counters cleared, in-flight read data discarded; no done pulse.

## Timing
- Reset values: busy 0, done 0, mem_rd_en 0, mem_rd_addr 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0.
- start at cycle 0 → busy and first mem_rd_en at cycle 1 → data in FIFO at cycle 3 → first tvalid at cycle 3.
- With tready held high: one read per RATIO cycles sustained once FIFO primed; full throughput = 1 beat/cycle.
- Simultaneous FIFO push and pop: both take effect; count unchanged.
- FIFO full: reads stall, resume the cycle after a pop frees a credit.
- done pulse the cycle after final handshake; next start accepted that cycle or later.

## Structure
- Shared package: VLW_WDT, TDATA_WDT, ADDR_WDT, FIFO_SIZE defaults, derived RATIO and FIFO address width, FSM state enum typedef (IDLE, READ, DRAIN).
- Sub-module: axis_sync_fifo (parametrised width VLW_WDT+1, depth FIFO_SIZE, count output, synchronous active-high flush on rst).

## Test plan
- Default params, frame_len_log2=2, base_addr=0, mem[i]={i,~i}, tready=1 → 8 beats i,~i in order, tlast on beat 7 only, done 1 cycle later.
- base_addr=4094, frame_len_log2=2 → reads 4094,4095,0,1; beats follow that order.
- Random tready (50%), frame_len_log2=12 → 8192 beats, no loss/duplication, tdata stable while tvalid&&!tready, FIFO never overflows.
- MSB_FIRST=0, word 0x1111_1111_2222_2222 → beats 0x22222222 then 0x11111111.
- start during busy, then rst at beat 5 of 16 → start ignored; after rst all outputs 0, no done; new frame runs cleanly.
- frame_len_log2=15 (>ADDR_WDT) → clamped to 4096 words, tlast at beat 8191.
